ins_fetch: RTL and testbench
============================

Name: ins_fetch

Overview:
- Instruction fetch stage and producer end of the decode interface: generates the PC and fetches 32-bit instruction words from instruction memory.
- Uses a req/ack handshake to memory.
- Presents registered ins_o/ins_addr_o/ins_valid_o to the decode stage.
- Supports downstream stall (hold_i) and branch/jump redirect (jump_en_i) with in-flight fetch discard.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value after reset.
- NOP_INS, 32'h0000_0013, word driven on ins_o during bubbles (addi x0,x0,0).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- hold_i  input  1  downstream stall; fetch outputs must not change while high
- jump_en_i  input  1  redirect request, priority over all other events
- jump_addr_i  input  32  redirect target
- mem_req_o  output  1  fetch request, combinational from state
- mem_addr_o  output  32  fetch word address, combinational from state/registers
- mem_ack_i  input  1  memory returns mem_rdata_i this cycle (sampled at edge while mem_req_o=1)
- mem_rdata_i  input  32  fetched instruction
- ins_o  output  32  instruction to decode (registered)
- ins_addr_o  output  32  address of ins_o (registered)
- ins_valid_o  output  1  ins_o is a real instruction (registered)
- fetch_cnt_o  output  32  only with FETCH_CNT_EN

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_ADDR, state=S_IDLE
  - ins_o=NOP_INS, ins_addr_o=0, ins_valid_o=0
  - buffer cleared
  - mem_req_o=0, mem_addr_o=RESET_ADDR
- States: S_IDLE, S_REQ, S_STALL, S_DRAIN. mem_req_o=1 in S_REQ and S_DRAIN only.
- mem_addr_o = pc in S_IDLE/S_REQ/S_STALL; = drain_addr in S_DRAIN.
- Memory rule: once mem_req_o=1, req and addr hold stable until the edge where mem_ack_i=1. Zero-wait memory acks in the same cycle, giving 1 instruction/cycle.
- S_IDLE: next edge -> S_REQ, outputs unchanged. Exactly one idle cycle after reset release.
- S_REQ, no jump:
  - ack=1, hold=0: ins_o<=mem_rdata_i, ins_addr_o<=pc, ins_valid_o<=1, pc<=pc+4; stay.
  - ack=1, hold=1: buf<=mem_rdata_i, buf_addr<=pc, pc<=pc+4, -> S_STALL; ins_* unchanged.
  - ack=0, hold=0: bubble, ins_o<=NOP_INS, ins_valid_o<=0, ins_addr_o unchanged; stay.
  - ack=0, hold=1: all unchanged; stay.
- S_STALL, no jump:
  - hold=1: unchanged.
  - hold=0: ins_o<=buf, ins_addr_o<=buf_addr, ins_valid_o<=1, -> S_REQ.
- S_DRAIN, no jump:
  - ack=1: returned data discarded, -> S_REQ.
  - ack=0: stay.
  - ins_valid_o=0 throughout; hold_i ignored.
- Jump (jump_en_i=1, any state except S_IDLE; overrides hold_i):
  - pc<={jump_addr_i[31:2],2'b00} (low bits forced to zero).
  - ins_o<=NOP_INS, ins_valid_o<=0, buffer invalidated.
  - Next state:
    - S_REQ with ack=0: drain_addr<=pc, -> S_DRAIN.
    - S_REQ with ack=1: data dropped, -> S_REQ.
    - S_STALL: -> S_REQ.
    - S_DRAIN with ack=0: stay, drain_addr unchanged; newest pc wins.
    - S_DRAIN with ack=1: -> S_REQ.
- Jump in S_IDLE: pc updated; state still -> S_REQ.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- Reset mid-fetch: outstanding request abandoned; memory must accept req dropping on reset.

Optional Feature:
- FETCH_CNT_EN defined:
  - fetch_cnt_o is present: 32-bit count of instructions delivered with ins_valid_o rising/held-new (increments on every edge that loads ins_o with valid=1).
  - Reset to 0, wraps at 2^32.
  - Dropped or drained words are not counted.
- FETCH_CNT_EN undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> mem_req_o=0 for 1 cycle; then ins_addr_o 0x0,0x4,0x8 on consecutive cycles with ins_valid_o=1, ins_o=0x0,0x4,0x8.
- ack delayed 3 cycles at pc=0x10 -> mem_addr_o held 0x10 for 3 cycles; ins_o=NOP_INS, valid=0; then ins_addr_o=0x10, valid=1.
- hold_i=1 for 4 cycles coinciding with ack at pc=0x20 -> ins_* frozen, mem_req_o=0 in S_STALL; after release ins_addr_o=0x20, next fetch 0x24.
- jump_en_i=1, jump_addr_i=0x103 while request to 0x40 outstanding -> mem_addr_o stays 0x40 until ack; that data is not presented; next fetch is 0x100; valid=0 until it returns.
- pc=0xFFFF_FFFC, zero-wait -> next mem_addr_o=0x0000_0000.
- With FETCH_CNT_EN: 10 delivered instructions plus one drained word -> fetch_cnt_o=10; async rst mid-run -> fetch_cnt_o=0 immediately.

Source files
------------

// File: rtl/ins_fetch.sv
// Instruction fetch: PC generation, req/ack fetch from instruction memory, registered decode-side outputs.
// Optional macro FETCH_CNT_EN adds fetch_cnt_o, a count of instructions delivered to decode.
module ins_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INS    = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hold_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o,
  output logic        ins_valid_o
`ifdef FETCH_CNT_EN
  ,
  output logic [31:0] fetch_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_STALL, S_DRAIN} state_e;

  state_e      state_q;
  logic [31:0] pc_q, drain_addr_q, buf_q, buf_addr_q;
  logic [31:0] ins_q, ins_addr_q;
  logic        ins_valid_q;

  logic [31:0] pc_inc_d, jump_pc_d;
  logic        deliver_d;

  assign pc_inc_d  = pc_q + 32'd4;
  assign jump_pc_d = {jump_addr_i[31:2], 2'b00};
  // An edge that loads ins_q with a real instruction.
  assign deliver_d = !jump_en_i && !hold_i &&
                     (((state_q == S_REQ) && mem_ack_i) || (state_q == S_STALL));

  assign mem_req_o   = (state_q == S_REQ) || (state_q == S_DRAIN);
  assign mem_addr_o  = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
  assign ins_o       = ins_q;
  assign ins_addr_o  = ins_addr_q;
  assign ins_valid_o = ins_valid_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_ADDR;
      drain_addr_q <= RESET_ADDR;
      buf_q        <= NOP_INS;
      buf_addr_q   <= '0;
      ins_q        <= NOP_INS;
      ins_addr_q   <= '0;
      ins_valid_q  <= 1'b0;
    end else if (state_q == S_IDLE) begin
      state_q <= S_REQ;
      if (jump_en_i) pc_q <= jump_pc_d;
    end else if (jump_en_i) begin
      // Redirect: an unacked request must still complete, so it is drained first.
      pc_q        <= jump_pc_d;
      ins_q       <= NOP_INS;
      ins_valid_q <= 1'b0;
      buf_q       <= NOP_INS;
      buf_addr_q  <= '0;
      case (state_q)
        S_REQ: begin
          if (!mem_ack_i) begin
            drain_addr_q <= pc_q;
            state_q      <= S_DRAIN;
          end
        end
        S_DRAIN: if (mem_ack_i) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (mem_ack_i) begin
            pc_q <= pc_inc_d;
            if (hold_i) begin
              buf_q      <= mem_rdata_i;
              buf_addr_q <= pc_q;
              state_q    <= S_STALL;
            end else begin
              ins_q       <= mem_rdata_i;
              ins_addr_q  <= pc_q;
              ins_valid_q <= 1'b1;
            end
          end else if (!hold_i) begin
            ins_q       <= NOP_INS;
            ins_valid_q <= 1'b0;
          end
        end
        S_STALL: begin
          if (!hold_i) begin
            ins_q       <= buf_q;
            ins_addr_q  <= buf_addr_q;
            ins_valid_q <= 1'b1;
            state_q     <= S_REQ;
          end
        end
        S_DRAIN: if (mem_ack_i) state_q <= S_REQ;
        default: state_q <= S_REQ;
      endcase
    end
  end

`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt_q;
  assign fetch_cnt_o = fetch_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            fetch_cnt_q <= '0;
    else if (deliver_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end
`else
  logic unused_deliver;
  assign unused_deliver = deliver_d;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Bench for ins_fetch: directed walk through the fetch scenarios, then random traffic
// checked against a program-order model of the delivered instruction stream.
module tb_ins_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0, rst = 1'b1;
  logic        hold_i = 1'b0, jump_en_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] jump_addr_i = '0, mem_rdata_i = '0;
  logic        mem_req_o, ins_valid_o;
  logic [31:0] mem_addr_o, ins_o, ins_addr_o;
`ifdef FETCH_CNT_EN
  logic [31:0] fetch_cnt_o;
`endif

  int          total = 0, bad = 0, exp_cnt = 0;
  bit          hashed = 1'b0, ack_en = 1'b0;

  ins_fetch dut (
    .clk(clk), .rst(rst), .hold_i(hold_i), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .ins_o(ins_o), .ins_addr_o(ins_addr_o),
    .ins_valid_o(ins_valid_o)
`ifdef FETCH_CNT_EN
    , .fetch_cnt_o(fetch_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return hashed ? ((a * 32'h9E37_79B1) ^ 32'h1234_5678) : a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Memory answers combinationally to the current request; inputs change at negedge.
  task automatic tick;
    mem_ack_i   = ack_en & mem_req_o;
    mem_rdata_i = mem_word(mem_addr_o);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ins(input logic [31:0] a);
    chk("ins_addr", ins_addr_o, a);
    chk("ins", ins_o, mem_word(a));
    chk("valid", {31'd0, ins_valid_o}, 32'd1);
    exp_cnt++;
  endtask

  task automatic chk_bubble;
    chk("bubble_ins", ins_o, NOP);
    chk("bubble_valid", {31'd0, ins_valid_o}, 32'd0);
  endtask

  initial begin
    logic        p_req, p_ack, p_hold, p_jump, p_v;
    logic [31:0] p_addr, p_ins, p_ia, p_jaddr, exp_next;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ins", ins_o, NOP);
    chk("rst_ins_addr", ins_addr_o, 32'h0);
    chk_bubble;
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    rst = 1'b0;
    chk("idle_req", {31'd0, mem_req_o}, 32'd0);
    ack_en = 1'b1;
    tick;
    chk("first_req", {31'd0, mem_req_o}, 32'd1);
    chk("first_addr", mem_addr_o, 32'h0);
    chk_bubble;

    // zero-wait streaming
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_ins(32'(i * 4));
    end
    chk("addr_10", mem_addr_o, 32'h10);

    // delayed ack
    ack_en = 1'b0;
    repeat (3) begin
      tick;
      chk("wait_addr", mem_addr_o, 32'h10);
      chk("wait_req", {31'd0, mem_req_o}, 32'd1);
      chk_bubble;
    end
    ack_en = 1'b1;
    tick;
    chk_ins(32'h10);
    for (int a = 'h14; a <= 'h1C; a += 4) begin
      tick;
      chk_ins(32'(a));
    end
    chk("addr_20", mem_addr_o, 32'h20);

    // hold coinciding with ack
    hold_i = 1'b1;
    repeat (4) begin
      tick;
      chk("hold_ins_addr", ins_addr_o, 32'h1C);
      chk("hold_valid", {31'd0, ins_valid_o}, 32'd1);
      chk("stall_req", {31'd0, mem_req_o}, 32'd0);
    end
    hold_i = 1'b0;
    tick;
    chk_ins(32'h20);
    chk("after_hold_addr", mem_addr_o, 32'h24);
    tick;
    chk_ins(32'h24);
    for (int a = 'h28; a <= 'h3C; a += 4) begin
      tick;
      chk_ins(32'(a));
    end
    chk("addr_40", mem_addr_o, 32'h40);

    // jump with an outstanding request: drain it, then fetch target
    ack_en = 1'b0;
    jump_en_i = 1'b1;
    jump_addr_i = 32'h103;
    tick;
    jump_en_i = 1'b0;
    chk("drain_addr", mem_addr_o, 32'h40);
    chk("drain_req", {31'd0, mem_req_o}, 32'd1);
    chk_bubble;
    tick;
    chk("drain_addr2", mem_addr_o, 32'h40);
    chk_bubble;
    ack_en = 1'b1;
    tick;
    chk_bubble;
    chk("jump_target", mem_addr_o, 32'h100);
    tick;
    chk_ins(32'h100);
`ifdef FETCH_CNT_EN
    chk("cnt_directed", fetch_cnt_o, 32'(exp_cnt));
`endif

    // jump while acked, then PC wrap
    jump_en_i = 1'b1;
    jump_addr_i = 32'hFFFF_FFFC;
    tick;
    jump_en_i = 1'b0;
    chk_bubble;
    chk("wrap_pre", mem_addr_o, 32'hFFFF_FFFC);
    tick;
    chk_ins(32'hFFFF_FFFC);
    chk("wrap_addr", mem_addr_o, 32'h0);
    tick;
    chk_ins(32'h0);

    // random traffic against program-order model
    @(negedge clk);
    rst = 1'b1;
    hashed = 1'b1;
    exp_cnt = 0;
    exp_next = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      hold_i      = ($urandom_range(0, 4) == 0);
      jump_en_i   = ($urandom_range(0, 15) == 0);
      jump_addr_i = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                 : 32'($urandom);
      ack_en      = ($urandom_range(0, 3) != 0);
      p_req = mem_req_o; p_addr = mem_addr_o;
      p_ins = ins_o; p_ia = ins_addr_o; p_v = ins_valid_o;
      p_hold = hold_i; p_jump = jump_en_i; p_jaddr = jump_addr_i;
      tick;
      p_ack = mem_ack_i;
      if (p_req && !p_ack) begin
        chk("proto_req", {31'd0, mem_req_o}, 32'd1);
        chk("proto_addr", mem_addr_o, p_addr);
      end
      if (p_jump) begin
        chk_bubble;
        exp_next = p_jaddr & 32'hFFFF_FFFC;
      end else if (p_hold) begin
        chk("frz_ins", ins_o, p_ins);
        chk("frz_addr", ins_addr_o, p_ia);
        chk("frz_valid", {31'd0, ins_valid_o}, {31'd0, p_v});
      end else if (ins_valid_o) begin
        chk_ins(exp_next);
        exp_next = exp_next + 32'd4;
      end
    end
`ifdef FETCH_CNT_EN
    chk("cnt_random", fetch_cnt_o, 32'(exp_cnt));
`endif

    // asynchronous reset mid-run
    hold_i = 1'b0;
    jump_en_i = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ins", ins_o, NOP);
    chk("arst_ins_addr", ins_addr_o, 32'h0);
    chk("arst_valid", {31'd0, ins_valid_o}, 32'd0);
    chk("arst_req", {31'd0, mem_req_o}, 32'd0);
    chk("arst_mem_addr", mem_addr_o, 32'h0);
`ifdef FETCH_CNT_EN
    chk("arst_cnt", fetch_cnt_o, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
